// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: input beat channel and output immediate channel.
// The producer/consumer side uses master; the generator itself uses slave.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ins;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic             out_sel_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_ins, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_sel_err, out_tag
  );

  modport slave (
    input  in_valid, in_ins, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_sel_err, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry output/skid buffer.
// Optional IMM_GEN_STATS_EN adds stat_err_cnt, a saturating count of reserved-select output beats.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  imm_gen_pipe_if.slave     bus
`ifdef IMM_GEN_STATS_EN
  ,
  output logic [15:0]       stat_err_cnt
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic [31:0]      ins;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_imm_q;
  logic             out_err_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic             skid_err_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic             in_fire;
  logic             out_fire;
  logic             unused_opcode;

  assign ins           = bus.in_ins;
  assign unused_opcode = ^ins[6:0];

  // Sign extension comes from sizing a $signed value up to XLEN.
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    unique case (bus.in_sel)
      3'b000: dec_imm = XLEN'($signed(ins[31:20]));
      3'b001: dec_imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      3'b010: dec_imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'b011: dec_imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'b100: dec_imm = XLEN'($signed({ins[31:12], 12'b0}));
      3'b101: dec_imm = XLEN'(ins[19:15]);
      3'b110: dec_imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
      default: begin
        dec_imm = '0;
        dec_err = 1'b1;
      end
    endcase
  end

  assign in_fire  = bus.in_valid && !skid_valid_q;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_err_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_err_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else if (out_fire && skid_valid_q) begin
      // in_ready is low whenever SKID is full, so no input can collide here.
      out_imm_q    <= skid_imm_q;
      out_err_q    <= skid_err_q;
      out_tag_q    <= skid_tag_q;
      skid_valid_q <= 1'b0;
    end else if (in_fire && (!out_valid_q || bus.out_ready)) begin
      out_valid_q <= 1'b1;
      out_imm_q   <= dec_imm;
      out_err_q   <= dec_err;
      out_tag_q   <= bus.in_tag;
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
      skid_imm_q   <= dec_imm;
      skid_err_q   <= dec_err;
      skid_tag_q   <= bus.in_tag;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef IMM_GEN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_err_cnt <= '0;
    end else if (out_fire && out_err_q && stat_err_cnt != '1) begin
      stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_sel_err = out_err_q;
  assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe, covering XLEN=32 and XLEN=64 instances.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_imm_gen_pipe;
  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

`ifdef IMM_GEN_STATS_EN
  logic [15:0] cnt32;
  logic [15:0] cnt64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
`ifdef IMM_GEN_STATS_EN
    ,
    .stat_err_cnt (cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
`ifdef IMM_GEN_STATS_EN
    ,
    .stat_err_cnt (cnt64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [4:0] tag);
    bus32.in_valid = v;
    bus32.in_ins   = ins;
    bus32.in_sel   = sel;
    bus32.in_tag   = tag;
  endtask

  task automatic drive64(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [4:0] tag);
    bus64.in_valid = v;
    bus64.in_ins   = ins;
    bus64.in_sel   = sel;
    bus64.in_tag   = tag;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    drive64(1'b0, 32'h0, 3'b000, 5'd0);
    bus32.out_ready = 1'b1;
    bus64.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_out_imm", 64'(bus32.out_imm), 64'd0);
    chk("rst_out_tag", 64'(bus32.out_tag), 64'd0);
    chk("rst_sel_err", 64'(bus32.out_sel_err), 64'd0);
    chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
    rst = 1'b0;

    // Single I-type beat, then back-to-back B, J, U
    @(negedge clk);
    drive32(1'b1, 32'hFFF00093, 3'b000, 5'd3);
    @(negedge clk);
    chk("i_valid", 64'(bus32.out_valid), 64'd1);
    chk("i_imm", 64'(bus32.out_imm), 64'hFFFFFFFF);
    chk("i_tag", 64'(bus32.out_tag), 64'd3);
    chk("i_err", 64'(bus32.out_sel_err), 64'd0);
    drive32(1'b1, 32'hFE000EE3, 3'b010, 5'd4);
    @(negedge clk);
    chk("b_imm", 64'(bus32.out_imm), 64'hFFFFFFFC);
    chk("b_tag", 64'(bus32.out_tag), 64'd4);
    chk("b_in_ready", 64'(bus32.in_ready), 64'd1);
    drive32(1'b1, 32'hFF9FF06F, 3'b011, 5'd5);
    @(negedge clk);
    chk("j_imm", 64'(bus32.out_imm), 64'hFFFFFFF8);
    chk("j_in_ready", 64'(bus32.in_ready), 64'd1);
    drive32(1'b1, 32'h123450B7, 3'b100, 5'd6);
    @(negedge clk);
    chk("u_imm", 64'(bus32.out_imm), 64'h12345000);
    chk("u_valid", 64'(bus32.out_valid), 64'd1);

    // S, Z, SH, reserved select on XLEN=32; parallel XLEN=64 beats
    drive32(1'b1, 32'h02112423, 3'b001, 5'd7);
    drive64(1'b1, 32'hFFF00093, 3'b000, 5'd1);
    @(negedge clk);
    chk("s_imm", 64'(bus32.out_imm), 64'h28);
    chk("x64_i_imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("x64_i_tag", 64'(bus64.out_tag), 64'd1);
    drive32(1'b1, 32'h000F8073, 3'b101, 5'd8);
    drive64(1'b1, 32'h03F01013, 3'b110, 5'd2);
    @(negedge clk);
    chk("z_imm", 64'(bus32.out_imm), 64'h1F);
    chk("x64_sh_imm", bus64.out_imm, 64'h3F);
    drive32(1'b1, 32'h03F01013, 3'b110, 5'd9);
    drive64(1'b1, 32'h800000B7, 3'b100, 5'd3);
    @(negedge clk);
    chk("sh32_imm", 64'(bus32.out_imm), 64'h1F);
    chk("x64_u_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    drive32(1'b1, 32'hFFFFFFFF, 3'b111, 5'd10);
    drive64(1'b0, 32'h0, 3'b000, 5'd0);
    @(negedge clk);
    chk("rsv_imm", 64'(bus32.out_imm), 64'd0);
    chk("rsv_err", 64'(bus32.out_sel_err), 64'd1);
    chk("rsv_tag", 64'(bus32.out_tag), 64'd10);
    chk("x64_drained", 64'(bus64.out_valid), 64'd0);
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    @(negedge clk);
    chk("idle_valid", 64'(bus32.out_valid), 64'd0);
    chk("idle_hold_imm", 64'(bus32.out_imm), 64'd0);
`ifdef IMM_GEN_STATS_EN
    chk("stat_cnt_one", 64'(cnt32), 64'd1);
    chk("stat_cnt64_zero", 64'(cnt64), 64'd0);
`endif

    // Back-pressure: A fills OUT, B fills SKID, C is held
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'h00500093, 3'b000, 5'd11);
    @(negedge clk);
    chk("bp_a_imm", 64'(bus32.out_imm), 64'd5);
    chk("bp_a_ready", 64'(bus32.in_ready), 64'd1);
    drive32(1'b1, 32'h00700093, 3'b000, 5'd12);
    @(negedge clk);
    chk("bp_hold_imm", 64'(bus32.out_imm), 64'd5);
    chk("bp_hold_tag", 64'(bus32.out_tag), 64'd11);
    chk("bp_skid_ready", 64'(bus32.in_ready), 64'd0);
    drive32(1'b1, 32'h00900093, 3'b000, 5'd13);
    @(negedge clk);
    chk("bp_c_blocked", 64'(bus32.in_ready), 64'd0);
    chk("bp_still_a", 64'(bus32.out_imm), 64'd5);
    chk("bp_still_valid", 64'(bus32.out_valid), 64'd1);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_imm", 64'(bus32.out_imm), 64'd7);
    chk("bp_b_tag", 64'(bus32.out_tag), 64'd12);
    chk("bp_b_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clk);
    chk("bp_c_imm", 64'(bus32.out_imm), 64'd9);
    chk("bp_c_tag", 64'(bus32.out_tag), 64'd13);
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    @(negedge clk);
    chk("bp_drained", 64'(bus32.out_valid), 64'd0);
    chk("bp_hold_last", 64'(bus32.out_imm), 64'd9);

    // Reset with OUT and SKID both full
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'h00300093, 3'b000, 5'd1);
    @(negedge clk);
    drive32(1'b1, 32'h00400093, 3'b000, 5'd2);
    @(negedge clk);
    chk("stall_full", 64'(bus32.in_ready), 64'd0);
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus32.out_valid), 64'd0);
    chk("arst_imm", 64'(bus32.out_imm), 64'd0);
    chk("arst_tag", 64'(bus32.out_tag), 64'd0);
`ifdef IMM_GEN_STATS_EN
    chk("arst_stat", 64'(cnt32), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_ready", 64'(bus32.in_ready), 64'd1);
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'h00100093, 3'b000, 5'd7);
    @(negedge clk);
    chk("post_rst_valid", 64'(bus32.out_valid), 64'd1);
    chk("post_rst_imm", 64'(bus32.out_imm), 64'd1);
    chk("post_rst_tag", 64'(bus32.out_tag), 64'd7);
    drive32(1'b0, 32'h0, 3'b000, 5'd0);
    @(negedge clk);
    chk("post_rst_drain", 64'(bus32.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
